fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction-fetch front end that consumes word addresses from the program counter, issues them to instruction memory over a req/ack handshake, and buffers returned instruction/address pairs in a small FIFO for the decode stage. It sits between the PC and decode: it back-pressures the PC through `pc_stall`, and flushes on redirects.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2
- `AW`, 32: address width; matches the PC count width
- `DW`, 32: instruction width
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low
- `pc_in`  in  AW  word address from the program counter
- `pc_valid`  in  1  `pc_in` offered this cycle
- `pc_stall`  out  1  combinational; high when `pc_in` cannot be accepted this cycle
- `flush`  in  1  discard queue contents and any in-flight response
- `mem_req`  out  1  memory read request, registered
- `mem_addr`  out  AW  request address, registered, stable while `mem_req` is high
- `mem_ack`  in  1  memory response valid; `mem_rdata` is sampled this cycle
- `mem_rdata`  in  DW  instruction word
- `dec_valid`  out  1  queue head valid
- `dec_instr`  out  DW  head instruction
- `dec_pc`  out  AW  head address
- `dec_ready`  in  1  decode consumes the head this cycle
- `count`  out  log2(DEPTH)+1  current queue occupancy

## Operation
- FSM states are `IDLE`, `REQ` and `DROP`.
  - `IDLE`: no request in flight.
  - `REQ`: request outstanding, response will be kept.
  - `DROP`: request outstanding, response will be discarded.
- Accept condition: `pc_valid && state==IDLE && count<DEPTH && !flush`. On accept, latch `pc_in` into `mem_addr`, set `mem_req`, and go to `REQ`.
- `pc_stall = (state!=IDLE) || (count==DEPTH)`. `flush` does not affect `pc_stall`. `pc_valid` is ignored during a flush cycle.
- In `REQ`, `mem_req` and `mem_addr` are held until `mem_ack`. On `mem_ack`, push `{mem_addr, mem_rdata}` at the tail, clear `mem_req`, and go to `IDLE`.
- A push never overflows, because a request is issued only when `count<DEPTH` and it is the only push source.
- Queue is show-ahead:
  - `dec_valid = (count!=0)`.
  - `dec_instr` and `dec_pc` come from the head entry.
  - Pop occurs on `dec_valid && dec_ready`.
- Push and pop in the same cycle leave `count` unchanged. `dec_ready` on an empty queue has no effect.
- Pointers wrap modulo `DEPTH`.
- `flush` has priority over push and pop. In the flush cycle:
  - `count`, head and tail go to 0.
  - In `REQ` without `mem_ack`, go to `DROP`; `mem_req` stays high because a request cannot be aborted.
  - In `REQ` with `mem_ack`, discard the data and go to `IDLE`.
  - In `DROP` or `IDLE`, stay in the current state.
- In `DROP`, `mem_ack` discards the data, clears `mem_req`, and moves to `IDLE`.
- Addresses pass through unmodified (word addressing, same units as the PC).

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `count`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `pc_stall`=0, state `IDLE`.
- Reset dominates `flush` and all other inputs.
- Reset asserted during `REQ` returns the block to `IDLE` and the response is ignored. Memory must tolerate `mem_req` dropping without an ack.
- Accept in cycle N: `mem_req` is high in N+1.
- `mem_ack` in cycle M (M≥N+1): `dec_valid` and the entry are visible in M+1, and the block is back in `IDLE` in M+1.
- Minimum PC-to-decode latency is 2 cycles. With zero-wait memory, peak throughput is one fetch per 2 cycles.
- Pop in cycle P: the next entry is at the head in P+1.

## Configuration
- `FETCH_QUEUE_PERF_EN`
  - Defined: adds output `perf_stall` (32 bits). It increments each cycle `pc_valid && pc_stall`, wraps at 2^32, resets to 0, and is not cleared by `flush`.
  - Undefined: port and counter are absent, and all other behaviour is identical.

## Test plan
- Zero-wait fetch:
  - Stimulus: reset, then `pc_in`=0 valid in cycle 1, ack with `mem_rdata`=0xDEADBEEF in cycle 2, `dec_ready`=1.
  - Required: `dec_valid`=1 with `dec_pc`=0, `dec_instr`=0xDEADBEEF in cycle 3; `count` returns to 0 in cycle 4.
- Fill to full:
  - Stimulus: `dec_ready`=0, offer `pc_in`=0,1,2,3,4 with immediate acks.
  - Required: `count` reaches 4 and `pc_stall`=1; address 4 is not issued until one `dec_ready` pop, after which `mem_addr`=4.
- Wait-state memory:
  - Stimulus: ack 5 cycles after request.
  - Required: `mem_req`/`mem_addr` stable for 5 cycles; `pc_stall`=1 throughout; exactly one entry pushed.
- Flush in flight:
  - Stimulus: queue holds 2 entries, request to address 7 outstanding, pulse `flush`, ack 3 cycles later with 0x1234.
  - Required: `count`=0 the next cycle; state `DROP`; ack discarded, `dec_valid` stays 0, block returns to `IDLE`.
- Simultaneous push/pop and wrap:
  - Stimulus: 10 back-to-back fetches with `dec_ready`=1.
  - Required: `count` never exceeds 1; decode sees addresses 0..9 in order with matching data across pointer wrap.
- Reset mid-operation:
  - Stimulus: assert `reset`=0 during `REQ` with 3 queued entries.
  - Required: next cycle all outputs at reset values; a late `mem_ack` pushes nothing. With `FETCH_QUEUE_PERF_EN`, `perf_stall`=0.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch front end with req/ack memory port and show-ahead queue
//
// Purpose: accepts word addresses from the PC, issues one memory read at a time,
// and buffers {address, instruction} pairs for decode. Redirects flush the queue
// and discard any response still in flight.
//
// Optional feature macro: FETCH_QUEUE_PERF_EN (adds o_perf_stall counter port).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   i_pc_in, i_pc_valid address offered by the PC
//   o_pc_stall          PC back-pressure (combinational)
//   i_flush             redirect: empty queue, drop in-flight response
//   o_mem_req/o_mem_addr, i_mem_ack/i_mem_rdata   instruction memory handshake
//   o_dec_valid/o_dec_instr/o_dec_pc, i_dec_ready  decode-side queue head
//   o_count             queue occupancy
//   o_perf_stall        cycles with pc_valid while stalled (FETCH_QUEUE_PERF_EN only)

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [AW-1:0]            i_pc_in,
  input  logic                     i_pc_valid,
  output logic                     o_pc_stall,
  input  logic                     i_flush,
  output logic                     o_mem_req,
  output logic [AW-1:0]            o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [DW-1:0]            i_mem_rdata,
  output logic                     o_dec_valid,
  output logic [DW-1:0]            o_dec_instr,
  output logic [AW-1:0]            o_dec_pc,
  input  logic                     i_dec_ready,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              o_perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_mem_req;
  logic            w_next_req;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_next_addr;

  logic [AW-1:0]   r_pc_q    [DEPTH];
  logic [DW-1:0]   r_instr_q [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;

  logic            w_full;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  assign w_full   = (r_count == L_FULL);
  assign w_accept = i_pc_valid && (r_state == IDLE) && !w_full && !i_flush;
  // Only a kept response can push; a flush in the ack cycle throws it away.
  assign w_push   = (r_state == REQ) && i_mem_ack && !i_flush;
  assign w_pop    = (r_count != '0) && i_dec_ready && !i_flush;

  assign o_pc_stall  = (r_state != IDLE) || w_full;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_dec_valid = (r_count != '0);
  assign o_dec_instr = r_instr_q[r_head];
  assign o_dec_pc    = r_pc_q[r_head];
  assign o_count     = r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mem_req  <= w_next_req;
      r_mem_addr <= w_next_addr;
    end
  end

  // A request cannot be withdrawn once issued, so a flush while waiting parks
  // in DROP with mem_req still high until the memory answers.
  always_comb begin
    w_next_state = r_state;
    w_next_req   = r_mem_req;
    w_next_addr  = r_mem_addr;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = REQ;
          w_next_req   = 1'b1;
          w_next_addr  = i_pc_in;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          w_next_state = IDLE;
          w_next_req   = 1'b0;
        end else if (i_flush) begin
          w_next_state = DROP;
        end
      end
      DROP: begin
        if (i_mem_ack) begin
          w_next_state = IDLE;
          w_next_req   = 1'b0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_req   = 1'b0;
      end
    endcase
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_q[r_tail]    <= r_mem_addr;
      r_instr_q[r_tail] <= i_mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_stall <= '0;
    end else if (i_pc_valid && o_pc_stall) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic            clock;
  logic            reset;
  logic [AW-1:0]   pc_in;
  logic            pc_valid;
  logic            pc_stall;
  logic            flush;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            dec_valid;
  logic [DW-1:0]   dec_instr;
  logic [AW-1:0]   dec_pc;
  logic            dec_ready;
  logic [2:0]      count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]     perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_pc_in     (pc_in),
    .i_pc_valid  (pc_valid),
    .o_pc_stall  (pc_stall),
    .i_flush     (flush),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_dec_valid (dec_valid),
    .o_dec_instr (dec_instr),
    .o_dec_pc    (dec_pc),
    .i_dec_ready (dec_ready),
    .o_count     (count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .o_perf_stall(perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: queue of entries plus "one request outstanding, keep or drop".
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          m_q[$];
  bit            m_busy;
  bit            m_drop;
  logic [AW-1:0] m_addr;
  int unsigned   m_perf;

  // Advance one clock; the model samples the inputs that were applied for this edge.
  task automatic step();
    @(posedge clock);
    if (!reset) begin
      m_q.delete();
      m_busy = 0;
      m_drop = 0;
      m_addr = '0;
      m_perf = 0;
    end else begin
      bit stall;
      bit acc;
      stall = m_busy || (m_q.size() == DEPTH);
      acc   = pc_valid && !stall && !flush;
      if (pc_valid && stall) m_perf++;
      if (flush) m_q.delete();
      else if (dec_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (m_busy && mem_ack) begin
        if (!m_drop && !flush) m_q.push_back({m_addr, mem_rdata});
        m_busy = 0;
      end else if (m_busy && flush) begin
        m_drop = 1;
      end
      if (acc) begin
        m_busy = 1;
        m_drop = 0;
        m_addr = pc_in;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    pc_valid = 0; pc_in = '0; flush = 0; mem_ack = 0; mem_rdata = '0; dec_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got %0d exp 0", mem_req); end
    n_checks++; if (mem_addr !== '0) begin n_errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (dec_valid !== 1'b0) begin n_errors++; $display("FAIL reset_dec_valid got %0d exp 0", dec_valid); end
    n_checks++; if (dec_instr !== '0 || dec_pc !== '0) begin n_errors++; $display("FAIL reset_dec_data got %h/%h exp 0/0", dec_pc, dec_instr); end
    n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL reset_pc_stall got %0d exp 0", pc_stall); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    dec_ready = 1; pc_valid = 1; pc_in = 32'h0;
    step();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_errors++; $display("FAIL zw_issue got req=%0d addr=%h exp 1/0", mem_req, mem_addr); end
    n_checks++; if (pc_stall !== 1'b1) begin n_errors++; $display("FAIL zw_stall got %0d exp 1", pc_stall); end
    pc_valid = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'hDEADBEEF) begin n_errors++; $display("FAIL zw_head got v=%0d pc=%h i=%h exp 1/0/deadbeef", dec_valid, dec_pc, dec_instr); end
    n_checks++; if (mem_req !== 1'b0 || pc_stall !== 1'b0) begin n_errors++; $display("FAIL zw_idle got req=%0d stall=%0d exp 0/0", mem_req, pc_stall); end
    step();
    n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin n_errors++; $display("FAIL zw_drain got count=%0d v=%0d exp 0/0", count, dec_valid); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] d [5];
    do_reset();
    dec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      pc_valid = 1; pc_in = i;
      step();
      pc_valid = 0; mem_ack = 1; mem_rdata = d[i];
      step();
      mem_ack = 0;
    end
    n_checks++; if (count !== 3'd4 || pc_stall !== 1'b1) begin n_errors++; $display("FAIL fill_full got count=%0d stall=%0d exp 4/1", count, pc_stall); end
    n_checks++; if (dec_pc !== 32'd0 || dec_instr !== d[0]) begin n_errors++; $display("FAIL fill_head got %h/%h exp 0/%h", dec_pc, dec_instr, d[0]); end
    pc_valid = 1; pc_in = 4;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (mem_req !== 1'b0 || pc_stall !== 1'b1) begin n_errors++; $display("FAIL fill_blocked got req=%0d stall=%0d exp 0/1", mem_req, pc_stall); end
    end
    dec_ready = 1;
    step();
    dec_ready = 0;
    n_checks++; if (count !== 3'd3 || mem_req !== 1'b0 || dec_pc !== 32'd1 || dec_instr !== d[1]) begin n_errors++; $display("FAIL fill_pop got count=%0d req=%0d pc=%h i=%h exp 3/0/1/%h", count, mem_req, dec_pc, dec_instr, d[1]); end
    step();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin n_errors++; $display("FAIL fill_issue4 got req=%0d addr=%h exp 1/4", mem_req, mem_addr); end
    d[4] = $urandom;
    pc_valid = 0; mem_ack = 1; mem_rdata = d[4];
    step();
    mem_ack = 0;
    n_checks++; if (count !== 3'd4 || mem_req !== 1'b0) begin n_errors++; $display("FAIL fill_refill got count=%0d req=%0d exp 4/0", count, mem_req); end
  endtask

  task automatic test_wait_state();
    logic [AW-1:0] a;
    logic [DW-1:0] dt;
    do_reset();
    a = $urandom; dt = $urandom;
    pc_valid = 1; pc_in = a;
    step();
    for (int i = 0; i < 5; i++) begin
      pc_in = $urandom;
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== a || pc_stall !== 1'b1 || count !== 3'd0) begin n_errors++; $display("FAIL ws_hold%0d got req=%0d addr=%h stall=%0d count=%0d exp 1/%h/1/0", i, mem_req, mem_addr, pc_stall, count, a); end
      if (i < 4) step();
    end
    pc_valid = 0; mem_ack = 1; mem_rdata = dt;
    step();
    mem_ack = 0;
    n_checks++; if (count !== 3'd1 || dec_pc !== a || dec_instr !== dt || mem_req !== 1'b0) begin n_errors++; $display("FAIL ws_push got count=%0d pc=%h i=%h req=%0d exp 1/%h/%h/0", count, dec_pc, dec_instr, mem_req, a, dt); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pc_valid = 1; pc_in = 20 + i;
      step();
      pc_valid = 0; mem_ack = 1; mem_rdata = $urandom;
      step();
      mem_ack = 0;
    end
    pc_valid = 1; pc_in = 7;
    step();
    pc_valid = 0; flush = 1;
    step();
    flush = 0;
    n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin n_errors++; $display("FAIL fl_clear got count=%0d v=%0d exp 0/0", count, dec_valid); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd7 || pc_stall !== 1'b1) begin n_errors++; $display("FAIL fl_drop got req=%0d addr=%h stall=%0d exp 1/7/1", mem_req, mem_addr, pc_stall); end
    step();
    step();
    mem_ack = 1; mem_rdata = 32'h1234;
    step();
    mem_ack = 0;
    n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0 || mem_req !== 1'b0 || pc_stall !== 1'b0) begin n_errors++; $display("FAIL fl_discard got count=%0d v=%0d req=%0d stall=%0d exp 0/0/0/0", count, dec_valid, mem_req, pc_stall); end
    pc_valid = 1; pc_in = 9;
    step();
    pc_valid = 0; mem_ack = 1; mem_rdata = 32'h5678;
    step();
    mem_ack = 0;
    n_checks++; if (count !== 3'd1 || dec_pc !== 32'd9 || dec_instr !== 32'h5678) begin n_errors++; $display("FAIL fl_recover got count=%0d pc=%h i=%h exp 1/9/5678", count, dec_pc, dec_instr); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] dt;
    do_reset();
    dec_ready = 1;
    for (int i = 0; i < 10; i++) begin
      pc_valid = 1; pc_in = i;
      step();
      n_checks++; if (count > 3'd1) begin n_errors++; $display("FAIL b2b_count_a%0d got %0d exp <=1", i, count); end
      dt = $urandom;
      pc_valid = 1; mem_ack = 1; mem_rdata = dt;
      step();
      mem_ack = 0;
      n_checks++; if (count !== 3'd1 || dec_pc !== AW'(i) || dec_instr !== dt) begin n_errors++; $display("FAIL b2b_head%0d got count=%0d pc=%h i=%h exp 1/%h/%h", i, count, dec_pc, dec_instr, i, dt); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1; pc_in = 40 + i;
      step();
      pc_valid = 0; mem_ack = 1; mem_rdata = $urandom;
      step();
      mem_ack = 0;
    end
    pc_valid = 1; pc_in = 50;
    step();
    pc_valid = 0;
    reset = 0;
    step();
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== '0 || count !== 3'd0 || dec_valid !== 1'b0 || dec_instr !== '0 || dec_pc !== '0 || pc_stall !== 1'b0) begin n_errors++; $display("FAIL rm_outputs got req=%0d addr=%h count=%0d v=%0d i=%h pc=%h stall=%0d exp all 0", mem_req, mem_addr, count, dec_valid, dec_instr, dec_pc, pc_stall); end
`ifdef FETCH_QUEUE_PERF_EN
    n_checks++; if (perf_stall !== 32'd0) begin n_errors++; $display("FAIL rm_perf got %0d exp 0", perf_stall); end
`endif
    reset = 1; mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ack = 0;
    n_checks++; if (count !== 3'd0 || dec_valid !== 1'b0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL rm_late_ack got count=%0d v=%0d req=%0d exp 0/0/0", count, dec_valid, mem_req); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset     = ($urandom_range(0, 199) != 0);
      pc_valid  = ($urandom_range(0, 9) < 7);
      pc_in     = $urandom;
      dec_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 19) == 0);
      mem_ack   = m_busy && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      step();
      n_checks++; if (count !== 3'(m_q.size())) begin n_errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", cyc, count, m_q.size()); end
      n_checks++; if (pc_stall !== (m_busy || m_q.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_stall c%0d got %0d", cyc, pc_stall); end
      n_checks++; if (mem_req !== m_busy) begin n_errors++; $display("FAIL rnd_req c%0d got %0d exp %0d", cyc, mem_req, m_busy); end
      if (m_busy) begin
        n_checks++; if (mem_addr !== m_addr) begin n_errors++; $display("FAIL rnd_addr c%0d got %h exp %h", cyc, mem_addr, m_addr); end
      end
      n_checks++; if (dec_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid c%0d got %0d", cyc, dec_valid); end
      if (m_q.size() != 0) begin
        n_checks++; if (dec_pc !== m_q[0].pc || dec_instr !== m_q[0].instr) begin n_errors++; $display("FAIL rnd_head c%0d got %h/%h exp %h/%h", cyc, dec_pc, dec_instr, m_q[0].pc, m_q[0].instr); end
      end
`ifdef FETCH_QUEUE_PERF_EN
      n_checks++; if (perf_stall !== m_perf) begin n_errors++; $display("FAIL rnd_perf c%0d got %0d exp %0d", cyc, perf_stall, m_perf); end
`endif
    end
    reset = 1;
    idle_inputs();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    m_busy = 0; m_drop = 0; m_addr = '0; m_perf = 0;
    test_reset();
    test_zero_wait();
    test_fill();
    test_wait_state();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
